// File: rtl/i2s_pkg.sv
// ============================================================================
// Module      : i2s_pkg
// Description : Shared types and defaults for the I2S receive deserializer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2s_pkg;

    typedef enum logic [1:0] {
        ALIGN = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_state_t;

    localparam int c_SAMPLE_W = 24;
    localparam int c_SLOT_W   = 32;
    localparam int c_IDX_W    = 6;

    localparam logic [c_IDX_W-1:0] c_IDX_MAX = '1;

endpackage

`default_nettype wire

// File: rtl/i2s_rx_if.sv
// ============================================================================
// Module      : i2s_rx_if
// Description : Codec serial pins plus decoded sample outputs of i2s_rx.
//               Carries mono_sample when I2S_RX_MONO_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface i2s_rx_if
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W = c_SAMPLE_W
);
    logic                i2s_bclk;
    logic                i2s_lr;
    logic                i2s_sd;
    logic [SAMPLE_W-1:0] left_sample;
    logic [SAMPLE_W-1:0] right_sample;
    logic                new_sample;
    logic                frame_err;
`ifdef I2S_RX_MONO_EN
    logic [SAMPLE_W-1:0] mono_sample;
`endif

    modport master (
        output i2s_bclk, i2s_lr, i2s_sd,
        input  left_sample, right_sample, new_sample, frame_err
`ifdef I2S_RX_MONO_EN
        , input mono_sample
`endif
    );

    modport slave (
        input  i2s_bclk, i2s_lr, i2s_sd,
        output left_sample, right_sample, new_sample, frame_err
`ifdef I2S_RX_MONO_EN
        , output mono_sample
`endif
    );

endinterface

`default_nettype wire

// File: rtl/i2s_sync_edge.sv
// ============================================================================
// Module      : i2s_sync_edge
// Description : Multi-flop synchronizer with a registered rising-edge strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_d1;
    logic                   r_d2;
    logic                   r_rise;

    // Edge detect runs on a retimed copy so the strobe lands a fixed two
    // cycles after the synchronized level appears.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
            r_d1   <= 1'b0;
            r_d2   <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
            r_d1   <= r_sync[SYNC_STAGES-1];
            r_d2   <= r_d1;
            r_rise <= r_d1 & ~r_d2;
        end
    end

    assign q    = r_sync[SYNC_STAGES-1];
    assign rise = r_rise;

endmodule

`default_nettype wire

// File: rtl/i2s_rx.sv
// ============================================================================
// Module      : i2s_rx
// Description : I2S receive deserializer producing paired signed L/R samples.
//               Optional I2S_RX_MONO_EN adds a registered (L+R)/2 output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_rx
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W    = c_SAMPLE_W,
    parameter int SLOT_W      = c_SLOT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic    clk,
    input  logic    reset,
    i2s_rx_if.slave bus
);

    logic w_rise, w_bclk_q, w_lr, w_lr_rise, w_sd, w_sd_rise;
    logic w_unused;

    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_bclk (
        .clk(clk), .reset(reset), .d(bus.i2s_bclk), .q(w_bclk_q), .rise(w_rise));
    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lr (
        .clk(clk), .reset(reset), .d(bus.i2s_lr), .q(w_lr), .rise(w_lr_rise));
    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sd (
        .clk(clk), .reset(reset), .d(bus.i2s_sd), .q(w_sd), .rise(w_sd_rise));

    assign w_unused = &{1'b0, w_bclk_q, w_lr_rise, w_sd_rise};

    i2s_state_t          r_state, w_state_nxt;
    logic                r_lr_prev;
    logic [c_IDX_W-1:0]  r_bit_idx;
    logic [SAMPLE_W-1:0] r_acc, r_left_hold, r_right_hold;
    logic                r_left_ok, r_fire, r_err;
    logic [SAMPLE_W-1:0] r_left_sample, r_right_sample;
    logic                r_new, r_ferr;

    logic                w_boundary, w_take, w_len_ok;
    logic [SAMPLE_W-1:0] w_slot;
    logic                w_close_left, w_close_right, w_fire, w_err;

    assign w_boundary = w_rise & (w_lr != r_lr_prev);
    assign w_take     = 32'(r_bit_idx) < 32'(SAMPLE_W);
    assign w_slot     = w_take ? {r_acc[SAMPLE_W-2:0], w_sd} : r_acc;
    assign w_len_ok   = (32'(r_bit_idx) + 32'd1) == 32'(SLOT_W);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ALIGN;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_close_left  = 1'b0;
        w_close_right = 1'b0;
        w_fire        = 1'b0;
        w_err         = 1'b0;
        if (w_boundary) begin
            case (r_state)
                ALIGN: if (!w_lr) w_state_nxt = LEFT;
                LEFT: if (w_lr) begin
                    w_close_left = 1'b1;
                    w_err        = ~w_len_ok;
                    w_state_nxt  = RIGHT;
                end
                RIGHT: if (!w_lr) begin
                    w_close_right = 1'b1;
                    w_err         = ~w_len_ok;
                    w_fire        = w_len_ok & r_left_ok;
                    w_state_nxt   = LEFT;
                end
                default: w_state_nxt = ALIGN;
            endcase
        end
    end

    // Boundary bit is folded into the closing slot via w_slot; the counter
    // restarts so the following rise is index 0 (MSB of the new slot).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lr_prev    <= 1'b0;
            r_bit_idx    <= '0;
            r_acc        <= '0;
            r_left_hold  <= '0;
            r_right_hold <= '0;
            r_left_ok    <= 1'b0;
            r_fire       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_rise) begin
                r_lr_prev <= w_lr;
                if (w_boundary) begin
                    r_bit_idx <= '0;
                    r_acc     <= '0;
                end else begin
                    if (r_bit_idx != c_IDX_MAX) r_bit_idx <= r_bit_idx + 1'b1;
                    r_acc <= w_slot;
                end
            end
            if (w_close_left) begin
                r_left_hold <= w_slot;
                r_left_ok   <= w_len_ok;
            end
            if (w_close_right) begin
                r_right_hold <= w_slot;
                r_left_ok    <= 1'b0;
            end
            r_fire <= w_fire;
            r_err  <= w_err;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_left_sample  <= '0;
            r_right_sample <= '0;
            r_new          <= 1'b0;
            r_ferr         <= 1'b0;
        end else begin
            r_new  <= r_fire;
            r_ferr <= r_err;
            if (r_fire) begin
                r_left_sample  <= r_left_hold;
                r_right_sample <= r_right_hold;
            end
        end
    end

    assign bus.left_sample  = r_left_sample;
    assign bus.right_sample = r_right_sample;
    assign bus.new_sample   = r_new;
    assign bus.frame_err    = r_ferr;

`ifdef I2S_RX_MONO_EN
    logic signed [SAMPLE_W:0] w_sum;
    logic [SAMPLE_W-1:0]      r_mono;

    assign w_sum = $signed({r_left_hold[SAMPLE_W-1], r_left_hold})
                 + $signed({r_right_hold[SAMPLE_W-1], r_right_hold});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      r_mono <= '0;
        else if (r_fire) r_mono <= SAMPLE_W'(w_sum >>> 1);
    end

    assign bus.mono_sample = r_mono;
`endif

endmodule

`default_nettype wire

// File: tb/tb_i2s_rx.sv
// ============================================================================
// Module      : tb_i2s_rx
// Description : Self-checking bench for i2s_rx (vector table, reset and
//               latency sequences, randomized stream against a slot model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2s_rx;
    import i2s_pkg::*;

    localparam int SW   = 24;
    localparam int SLOT = 32;
    localparam int SS   = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    i2s_rx_if #(.SAMPLE_W(SW)) bus();

    i2s_rx #(.SAMPLE_W(SW), .SLOT_W(SLOT), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset), .bus(bus));

    typedef struct packed { logic lr; logic sd; } rise_t;
    typedef struct packed { logic err; logic [SW-1:0] l; logic [SW-1:0] r; } evt_t;
    typedef struct {
        logic [SW-1:0] l, r;
        int            len_l, len_r, e_new, e_err;
        logic [SW-1:0] x_l, x_r, x_m;
        bit            lat_chk;
    } vec_t;

    int    n_vec = 0, n_bad = 0, n_new = 0, n_err = 0;
    int    half = 16, pre = 0;
    logic  carry = 1'b0;
    rise_t rec_q[$];
    evt_t  dut_q[$], exp_q[$];
    vec_t  tbl[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One bclk period: data/lr change while bclk is low, rise mid-period.
    task automatic drive_rise(input logic lr, input logic sd);
        rise_t r;
        @(negedge clk);
        bus.i2s_bclk = 1'b0; bus.i2s_lr = lr; bus.i2s_sd = sd;
        repeat (half) @(negedge clk);
        r.lr = lr; r.sd = sd;
        rec_q.push_back(r);
        bus.i2s_bclk = 1'b1;
        repeat (half - 1) @(negedge clk);
    endtask

    // Slot of len bits; its LSB is carried to the first rise of the next phase.
    task automatic send_slot(input logic lr, input logic [SW-1:0] word, input int len);
        logic bits[64];
        for (int k = 0; k < len; k++)
            bits[k] = (k < SW) ? word[SW-1-k] : 1'($urandom);
        for (int i = pre; i < len; i++)
            drive_rise(lr, (i == 0) ? carry : bits[i-1]);
        carry = bits[len-1];
        pre = 0;
    endtask

    // Drives the closing 1->0 boundary rise and counts clk edges to the event.
    task automatic flush(output int lat);
        rise_t r;
        @(negedge clk);
        bus.i2s_bclk = 1'b0; bus.i2s_lr = 1'b0; bus.i2s_sd = carry;
        repeat (half) @(negedge clk);
        r.lr = 1'b0; r.sd = carry;
        rec_q.push_back(r);
        bus.i2s_bclk = 1'b1;
        lat = -1;
        for (int c = 0; c < 24 && lat < 0; c++) begin
            @(posedge clk); #1;
            if (bus.new_sample || bus.frame_err) lat = c;
        end
        pre = 1;
    endtask

    function automatic logic [SW-1:0] slot_value(input int a, input int b);
        logic [SW-1:0] v = '0;
        for (int k = 0; k < SW && a + k <= b; k++) v = {v[SW-2:0], rec_q[a+k].sd};
        return v;
    endfunction

    // Reference: split the recorded rise stream into slots at lr changes.
    task automatic build_expected();
        logic          prev = 1'b0;
        bit            aligned = 0, left_ok = 0;
        int            last_b = -1;
        logic [SW-1:0] lval = '0, val;
        evt_t          e;
        exp_q.delete();
        for (int i = 0; i < rec_q.size(); i++) begin
            if (rec_q[i].lr != prev) begin
                if (aligned) begin
                    int len;
                    len = i - last_b;
                    val = slot_value(last_b + 1, i);
                    if (len != SLOT) begin
                        e = {1'b1, {SW{1'b0}}, {SW{1'b0}}};
                        exp_q.push_back(e);
                        left_ok = 0;
                    end else if (prev == 1'b0) begin
                        left_ok = 1; lval = val;
                    end else if (left_ok) begin
                        e = {1'b0, lval, val};
                        exp_q.push_back(e);
                    end
                    if (prev == 1'b1) left_ok = 0;
                end else if (rec_q[i].lr == 1'b0) begin
                    aligned = 1;
                end
                last_b = i;
                prev = rec_q[i].lr;
            end
        end
    endtask

    logic [SW-1:0] pl = '0, pr = '0;
    always @(posedge clk) begin
        #1;
        if (bus.new_sample) begin
            n_new++;
            dut_q.push_back({1'b0, bus.left_sample, bus.right_sample});
            n_vec++;
            if (bus.frame_err) begin
                n_bad++;
                $display("FAIL excl: new_sample and frame_err both 1, required exclusive");
            end
        end
        if (bus.frame_err) begin
            n_err++;
            dut_q.push_back({1'b1, {SW{1'b0}}, {SW{1'b0}}});
        end
        if (reset && !bus.new_sample && (bus.left_sample !== pl || bus.right_sample !== pr)) begin
            n_vec++; n_bad++;
            $display("FAIL hold: outputs %h/%h changed without new_sample, required %h/%h",
                     bus.left_sample, bus.right_sample, pl, pr);
        end
        pl = bus.left_sample;
        pr = bus.right_sample;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int lat, b_new, b_err;
        tbl[0] = '{24'h123456, 24'hABCDEF, 32, 32, 1, 0, 24'h123456, 24'hABCDEF, 24'hDF0122, 1};
        tbl[1] = '{24'h111111, 24'h222222, 32, 16, 0, 1, 24'h123456, 24'hABCDEF, 24'hDF0122, 1};
        tbl[2] = '{24'h0F0F0F, 24'h1E1E1E, 32, 32, 1, 0, 24'h0F0F0F, 24'h1E1E1E, 24'h169696, 1};
        tbl[3] = '{24'h800000, 24'h7FFFFF, 32, 32, 1, 0, 24'h800000, 24'h7FFFFF, 24'hFFFFFF, 1};
        tbl[4] = '{24'h400000, 24'h400000, 32, 32, 1, 0, 24'h400000, 24'h400000, 24'h400000, 1};
        tbl[5] = '{24'h555555, 24'hAAAAAA, 20, 32, 0, 1, 24'h400000, 24'h400000, 24'h400000, 0};
        tbl[6] = '{24'h000005, 24'hFFFFFE, 32, 32, 1, 0, 24'h000005, 24'hFFFFFE, 24'h000001, 1};
        tbl[7] = '{24'h333333, 24'h444444, 10, 10, 0, 2, 24'h000005, 24'hFFFFFE, 24'h000001, 1};
        tbl[8] = '{24'h654321, 24'h0ABCDE, 32, 40, 0, 1, 24'h000005, 24'hFFFFFE, 24'h000001, 1};
        tbl[9] = '{24'h7E7E7E, 24'h010101, 32, 32, 1, 0, 24'h7E7E7E, 24'h010101, 24'h3FBFBF, 1};

        bus.i2s_bclk = 1'b0; bus.i2s_lr = 1'b0; bus.i2s_sd = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_left", bus.left_sample, 0);
        check("rst_right", bus.right_sample, 0);
        check("rst_new", bus.new_sample, 0);
        check("rst_err", bus.frame_err, 0);
`ifdef I2S_RX_MONO_EN
        check("rst_mono", bus.mono_sample, 0);
`endif
        reset = 1'b1;

        // Stream joins in the middle of a right slot.
        for (int i = 0; i < 10; i++) drive_rise(1'b1, 1'($urandom));
        repeat (8) @(negedge clk);
        check("no_early_out", dut_q.size(), 0);

        for (int i = 0; i < 10; i++) begin
            b_new = n_new; b_err = n_err;
            send_slot(1'b0, tbl[i].l, tbl[i].len_l);
            send_slot(1'b1, tbl[i].r, tbl[i].len_r);
            flush(lat);
            repeat (4) @(negedge clk);
            check($sformatf("r%0d_new", i), n_new - b_new, tbl[i].e_new);
            check($sformatf("r%0d_err", i), n_err - b_err, tbl[i].e_err);
            check($sformatf("r%0d_left", i), bus.left_sample, tbl[i].x_l);
            check($sformatf("r%0d_right", i), bus.right_sample, tbl[i].x_r);
`ifdef I2S_RX_MONO_EN
            check($sformatf("r%0d_mono", i), bus.mono_sample, tbl[i].x_m);
`endif
            if (tbl[i].lat_chk) check($sformatf("r%0d_lat", i), lat, SS + 3);
        end

        // Reset in the middle of a left slot.
        for (int i = 0; i < 8; i++) drive_rise(1'b0, 1'($urandom));
        @(negedge clk);
        bus.i2s_bclk = 1'b0;
        repeat (half) @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_left", bus.left_sample, 0);
        check("mid_rst_right", bus.right_sample, 0);
        check("mid_rst_new", bus.new_sample, 0);
`ifdef I2S_RX_MONO_EN
        check("mid_rst_mono", bus.mono_sample, 0);
`endif
        repeat (3) @(negedge clk);
        reset = 1'b1;
        rec_q.delete(); dut_q.delete();
        pre = 0;
        for (int i = 0; i < 20; i++) drive_rise(1'b0, 1'($urandom));
        send_slot(1'b1, 24'($urandom), 32);
        send_slot(1'b0, 24'hC0FFEE, 32);
        send_slot(1'b1, 24'h0BEEF1, 32);
        check("realign_quiet", dut_q.size(), 0);
        flush(lat);
        repeat (4) @(negedge clk);
        check("realign_cnt", dut_q.size(), 1);
        check("realign_left", bus.left_sample, 24'hC0FFEE);
        check("realign_right", bus.right_sample, 24'h0BEEF1);
        check("realign_lat", lat, SS + 3);

        // Randomized pairs at a faster bit clock, checked against the model.
        half = 6;
        for (int i = 0; i < 24; i++) begin
            int ll, lr_len;
            ll     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 40)) : SLOT;
            lr_len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 40)) : SLOT;
            send_slot(1'b0, 24'($urandom), ll);
            send_slot(1'b1, 24'($urandom), lr_len);
        end
        flush(lat);
        repeat (8) @(negedge clk);
        build_expected();
        check("rand_evt_count", dut_q.size(), exp_q.size());
        for (int i = 0; i < dut_q.size() && i < exp_q.size(); i++)
            check($sformatf("rand_evt%0d", i), dut_q[i], exp_q[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- Receive-side I2S deserializer for the ADAU1761 ADC path: the reverse direction of the existing headphone-out path.
- Takes the codec's serial data (AC_GPIO1), bit clock (AC_GPIO2) and LR clock (AC_GPIO3), all asynchronous to clk_100.
- Emits 24-bit signed left/right samples with a one-cycle new_sample strobe in the clk domain.
- Feeds line-in audio into the echo/adsr/wave_display chain in place of, or mixed with, music_player output.

Parameters:
SAMPLE_W, 24, captured bits per channel (MSB-first); must be ≤ SLOT_W
SLOT_W, 32, expected bclk periods per channel slot
SYNC_STAGES, 2, flip-flops in each input synchronizer (≥2)

Ports:
clk  input  1  system clock (clk_100 domain)
reset  input  1  asynchronous, active-low reset
i2s_bclk  input  1  codec bit clock, async
i2s_lr  input  1  codec LR clock, async; 0 = left slot, 1 = right slot
i2s_sd  input  1  codec serial data, async
left_sample  output  SAMPLE_W  last complete left sample, signed
right_sample  output  SAMPLE_W  last complete right sample, signed
new_sample  output  1  one-cycle pulse when left_sample/right_sample update together
frame_err  output  1  one-cycle pulse when a slot length ≠ SLOT_W

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0; state ALIGN; counters and accumulators 0.
- Synchronization:
  - bclk, lr and sd each pass through SYNC_STAGES flops.
  - A rising edge of the synced bclk produces a one-cycle "rise" strobe.
  - lr and sd are sampled only on rise.
- I2S framing:
  - At a rise, the bit is a "boundary bit" if the sampled lr differs from the lr sampled at the previous rise.
  - The boundary bit is the LSB position of the slot being closed (one-bclk I2S delay).
  - The bit at the next rise is the MSB of the new slot.
- Slot counter:
  - bit_idx resets to 0 at each boundary; increments per rise; saturates at 63.
  - Bits with bit_idx < SAMPLE_W shift MSB-first into the slot accumulator; later bits are ignored.
  - Slot length = bit_idx at the boundary + 1, counting the boundary bit.
  - The boundary bit enters the accumulator only if its index is < SAMPLE_W.
- States:
  - ALIGN: ignore data. On a boundary with lr 1→0 → LEFT, clear accumulator and bit_idx.
  - LEFT: on a boundary with lr 0→1, close the left slot into a hold register and set a left_ok flag → RIGHT.
  - RIGHT: on a boundary with lr 1→0, close the right slot. If left_ok and the right slot is good, load left_sample and right_sample together and pulse new_sample. → LEFT.
- Slot error: length ≠ SLOT_W → frame_err pulse. The pair containing that slot is discarded; outputs hold their previous values; the FSM still advances normally, with no realignment.
- Latency: new_sample and frame_err assert exactly 2 clk cycles after the rise strobe of the closing boundary. That is SYNC_STAGES+3 cycles after the clk edge that first samples raw bclk high at the boundary.
- new_sample and frame_err are mutually exclusive in a cycle. Outputs are stable from the update until the next new_sample.
- bclk stalls: no strobes; outputs hold indefinitely.
- Reset mid-frame: immediate return to ALIGN. The first new_sample requires a full left+right pair after the next 1→0 lr boundary.
- Minimum clk/bclk ratio is 8; at clk_100 with bclk 3.072 MHz the ratio is about 32.

Optional Feature:
- Macro: I2S_RX_MONO_EN.
- When defined, adds an output mono_sample [SAMPLE_W] = (left + right) >>> 1.
  - Computed at SAMPLE_W+1 bits, arithmetic shift, truncated.
  - Registered in the same cycle as new_sample; resets to 0.
- When undefined, the port and logic are absent.

Decomposition:
- Package i2s_pkg holds:
  - state enum (ALIGN, LEFT, RIGHT)
  - default SAMPLE_W/SLOT_W constants
  - bit_idx width constant (6)
- Sub-module i2s_sync_edge: SYNC_STAGES synchronizer plus a registered rising-edge strobe.
  - Instantiated for bclk (edge used); lr and sd use its synced output only.

Test Plan:
1. bclk period 32 clk, 32-bit slots, left=24'h123456, right=24'hABCDEF → exactly one new_sample, left_sample=24'h123456, right_sample=24'hABCDEF, frame_err never high.
2. Stream starts mid-right slot with lr=1 → no output until after the first 1→0 boundary and a following full pair; the first pair seen is dropped, with no partial sample.
3. Right slot shortened to 16 bclk (SLOT_W=32) → one frame_err pulse, no new_sample, outputs keep their prior values; the next correct pair produces new_sample normally.
4. Assert reset mid-left slot for 3 cycles → all outputs 0 immediately; the first new_sample appears only after realignment plus a full pair.
5. left=24'h800000, right=24'h7FFFFF → correct signed outputs. With I2S_RX_MONO_EN, mono_sample=24'hFFFFFF; a later left=right=24'h400000 gives mono 24'h400000.
6. Latency check: count clk cycles from the first clk edge sampling raw bclk high at the closing boundary to new_sample → exactly SYNC_STAGES+3 (5 at default).
